// File: rtl/divisor_sequencial_pkg.sv
// rtl/divisor_sequencial_pkg.sv - shared state encodings and default widths for the sequential divider
package divisor_sequencial_pkg;

    localparam int DIV_N = 16;
    localparam int DIV_M = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/divisor_sequencial_subtrator_nbits.sv
// rtl/divisor_sequencial_subtrator_nbits.sv - W-bit ripple-borrow subtractor built from full-subtractor cells
module subtrator_nbits #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] difference,
    output logic         borrow_out
);

    logic [W:0] borrow;

    assign borrow[0] = 1'b0;

    genvar i;
    generate
        for (i = 0; i < W; i++) begin : g_cell
            assign difference[i] = a[i] ^ b[i] ^ borrow[i];
            assign borrow[i+1]   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
        end
    endgenerate

    assign borrow_out = borrow[W];

endmodule

// File: rtl/divisor_sequencial.sv
// rtl/divisor_sequencial.sv - restoring divider, one quotient bit per clock (shift-and-subtract)
module divisor_sequencial
    import divisor_sequencial_pkg::*;
#(
    parameter int N = DIV_N,
    parameter int M = DIV_M
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [M-1:0] divisor,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [M-1:0] remainder,
    output logic         div_zero
);

    localparam int CNT_W = $clog2(N + 1);

    div_state_t       state_q, state_d;
    logic [M:0]       r_q, r_d;
    logic [N-1:0]     q_q, q_d;
    logic [M-1:0]     d_q, d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     quotient_q, quotient_d;
    logic [M-1:0]     remainder_q, remainder_d;
    logic             div_zero_q, div_zero_d;
    logic             done_q, done_d;

    logic [M:0]       r_shift;
    logic [M:0]       trial;
    logic             restore;

    // R never reaches D, so its top bit is dropped by the shift
    assign r_shift = {r_q[M-1:0], q_q[N-1]};

    subtrator_nbits #(.W(M + 1)) u_sub (
        .a          (r_shift),
        .b          ({1'b0, d_q}),
        .difference (trial),
        .borrow_out (restore)
    );

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        q_d         = q_q;
        d_d         = d_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend[M-1:0];
                        div_zero_d  = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        r_d        = '0;
                        q_d        = dividend;
                        d_d        = divisor;
                        cnt_d      = '0;
                        div_zero_d = 1'b0;
                        state_d    = ST_ITER;
                    end
                end
            end
            ST_ITER: begin
                r_d   = restore ? r_shift : trial;
                q_d   = {q_q[N-2:0], ~restore};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(N - 1)) begin
                    quotient_d  = q_d;
                    remainder_d = r_d[M-1:0];
                    state_d     = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The pulse is registered one edge after DONE so the outputs it qualifies are already settled
    assign done_d = (state_q == ST_DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            q_q         <= q_d;
            d_q         <= d_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            done_q      <= done_d;
        end
    end

    a_r_msb_zero: assert property (@(posedge clock) disable iff (reset) !r_q[M]);

    assign ready     = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

endmodule
